// File: rtl/hazard_ctrl_pkg.sv
// Shared register-address types and constants for the MIPS hazard interlock.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t NOP_REG_ADDR = '0;
    localparam int        HAZ_DEPTH    = 3;
    localparam logic      ENABLE       = 1'b1;
    localparam logic      DISABLE      = 1'b0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } halt_state_e;

endpackage

// File: rtl/hazard_ctrl_dest_pipe.sv
// Shift register of in-flight destination registers (EX, MEM, WB, ...)
// with a bubble input and per-slot match vectors for two query addresses.
module dest_pipe
    import hazard_ctrl_pkg::*;
#(
    parameter int DEPTH = HAZ_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bubble_i,
    input  logic [REG_ADDR_W-1:0] dest_i,
    input  logic [REG_ADDR_W-1:0] query1_i,
    input  logic [REG_ADDR_W-1:0] query2_i,
    output logic [DEPTH-1:0]      match1_o,
    output logic [DEPTH-1:0]      match2_o
);

    logic [DEPTH-1:0][REG_ADDR_W-1:0] slot_q;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] slot_d;

    // A bubble enters EX as $0 so a stalled instruction is never tracked twice.
    always_comb begin
        slot_d    = slot_q;
        slot_d[0] = bubble_i ? NOP_REG_ADDR : dest_i;
        for (int k = 1; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        match1_o = '0;
        match2_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match1_o[k] = (query1_i != NOP_REG_ADDR) && (query1_i == slot_q[k]);
            match2_o[k] = (query2_i != NOP_REG_ADDR) && (query2_i == slot_q[k]);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall-based RAW interlock for the five-stage core: drives bbl from ID
// source reads against in-flight destinations, plus sticky halt and a stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DEPTH = HAZ_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exp_read1,
    input  logic [REG_ADDR_W-1:0] exp_addr1,
    input  logic                  exp_read2,
    input  logic [REG_ADDR_W-1:0] exp_addr2,
    input  logic [REG_ADDR_W-1:0] tar_addr,
    input  logic                  stop,
    output logic                  bbl,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt
);

    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;
    reg_addr_t        query1;
    reg_addr_t        query2;
    logic             hazard;
    halt_state_e      state_q;
    logic             halted_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A disabled read port queries $0, which never matches a tracked slot.
    assign query1 = exp_read1 ? exp_addr1 : NOP_REG_ADDR;
    assign query2 = exp_read2 ? exp_addr2 : NOP_REG_ADDR;

    dest_pipe #(
        .DEPTH(DEPTH)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (bbl),
        .dest_i   (tar_addr),
        .query1_i (query1),
        .query2_i (query2),
        .match1_o (match1),
        .match2_o (match2)
    );

    assign hazard    = (|match1) | (|match2);
    assign bbl       = (!rst && (hazard || halted_q || stop)) ? ENABLE : DISABLE;
    assign halted    = halted_q;
    assign stall_cnt = cnt_q;

    // Only genuine RAW stalls count; a stop in the same cycle takes precedence.
    always_comb begin
        cnt_d = cnt_q;
        if (hazard && !halted_q && !stop) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stop) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state_q  <= ST_HALT;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a queue scoreboard and a negedge monitor.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       exp_read1;
    logic [4:0] exp_addr1;
    logic       exp_read2;
    logic [4:0] exp_addr2;
    logic [4:0] tar_addr;
    logic       stop;
    logic       bbl;
    logic       halted;
    logic [15:0] stall_cnt;
    logic       bbl_s;
    logic       halted_s;
    logic [3:0] stall_cnt_s;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string name;
        int    eb;
        int    eh;
        int    ec;
        int    es;
        bit    cs;
    } exp_t;

    exp_t sb[$];

    hazard_ctrl #(.DEPTH(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .exp_read1(exp_read1), .exp_addr1(exp_addr1),
        .exp_read2(exp_read2), .exp_addr2(exp_addr2),
        .tar_addr(tar_addr), .stop(stop),
        .bbl(bbl), .halted(halted), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.DEPTH(3), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .exp_read1(exp_read1), .exp_addr1(exp_addr1),
        .exp_read2(exp_read2), .exp_addr2(exp_addr2),
        .tar_addr(tar_addr), .stop(stop),
        .bbl(bbl_s), .halted(halted_s), .stall_cnt(stall_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of ID inputs and queue what the DUT must show in that cycle.
    // eb/eh/ec/es of -1 skip that field; es is the 4-bit counter of dut_sat.
    task automatic cyc(input string nm, input logic r, input logic rd1, input logic [4:0] a1,
                       input logic rd2, input logic [4:0] a2, input logic [4:0] tar,
                       input logic stp, input int eb, input int eh, input int ec,
                       input int es, input bit cs);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; exp_read1 = rd1; exp_addr1 = a1; exp_read2 = rd2; exp_addr2 = a2;
        tar_addr = tar; stop = stp;
        e.name = nm; e.eb = eb; e.eh = eh; e.ec = ec; e.es = es; e.cs = cs;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.eb >= 0) begin
                    tests_run++;
                    if (int'(bbl) != e.eb) begin
                        tests_failed++;
                        $display("FAIL %s bbl: got %0d want %0d", e.name, bbl, e.eb);
                    end
                end
                if (e.eh >= 0) begin
                    tests_run++;
                    if (int'(halted) != e.eh) begin
                        tests_failed++;
                        $display("FAIL %s halted: got %0d want %0d", e.name, halted, e.eh);
                    end
                end
                if (e.ec >= 0) begin
                    tests_run++;
                    if (int'(stall_cnt) != e.ec) begin
                        tests_failed++;
                        $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.ec);
                    end
                end
                if (e.es >= 0) begin
                    tests_run++;
                    if (int'(stall_cnt_s) != e.es) begin
                        tests_failed++;
                        $display("FAIL %s sat_cnt: got %0d want %0d", e.name, stall_cnt_s, e.es);
                    end
                end
                if (e.cs) begin
                    tests_run++;
                    if (dut.u_pipe.slot_q != '0) begin
                        tests_failed++;
                        $display("FAIL %s slots: got %h want 0", e.name, dut.u_pipe.slot_q);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hz;
        rst = 1'b1; exp_read1 = 1'b0; exp_addr1 = '0; exp_read2 = 1'b0; exp_addr2 = '0;
        tar_addr = '0; stop = 1'b0;

        // Reset state
        cyc("reset",      1, 0, 0,  0, 0,  0,  0, 0, 0, 0, 0, 1);
        cyc("reset2",     1, 0, 0,  0, 0,  0,  0, 0, 0, 0, 0, 1);

        // Basic RAW stall: producer r5, consumer right behind it
        cyc("raw_issue",  0, 0, 0,  0, 0,  5,  0, 0, 0, 0, 0, 0);
        cyc("raw_st1",    0, 1, 5,  0, 0,  0,  0, 1, 0, 0, 0, 0);
        cyc("raw_st2",    0, 1, 5,  0, 0,  0,  0, 1, 0, 1, 1, 0);
        cyc("raw_st3",    0, 1, 5,  0, 0,  0,  0, 1, 0, 2, 2, 0);
        cyc("raw_go",     0, 1, 5,  0, 0,  0,  0, 0, 0, 3, 3, 0);
        cyc("raw_after",  0, 0, 0,  0, 0,  0,  0, 0, 0, 3, 3, 1);

        // Register zero and read enables
        cyc("r0_issue",   0, 0, 0,  0, 0,  0,  0, 0, -1, 3, 3, 0);
        cyc("r0_read",    0, 1, 0,  0, 0,  0,  0, 0, -1, 3, 3, 0);
        cyc("r7_issue",   0, 0, 0,  0, 0,  7,  0, 0, -1, 3, 3, 0);
        cyc("r7_noread",  0, 0, 0,  0, 7,  0,  0, 0, -1, 3, 3, 0);
        cyc("idle_a",     0, 0, 0,  0, 0,  0,  0, 0, -1, 3, 3, 0);
        cyc("idle_b",     0, 0, 0,  0, 0,  0,  0, 0, -1, 3, 3, 0);

        // Distance and dual match: r9, r10, one nop, then read both
        // (r9 gap 2 -> 1 stall, r10 gap 1 -> 2 stalls, overlapping -> 2 total)
        cyc("dual_p9",    0, 0, 0,  0, 0,  9,  0, 0, -1, 3, 3, 0);
        cyc("dual_p10",   0, 0, 0,  0, 0, 10,  0, 0, -1, 3, 3, 0);
        cyc("dual_nop",   0, 0, 0,  0, 0,  0,  0, 0, -1, 3, 3, 0);
        cyc("dual_st1",   0, 1, 9,  1, 10, 0,  0, 1, -1, 3, 3, 0);
        cyc("dual_st2",   0, 1, 9,  1, 10, 0,  0, 1, -1, 4, 4, 0);
        cyc("dual_go",    0, 1, 9,  1, 10, 0,  0, 0, -1, 5, 5, 0);
        cyc("dual_after", 0, 0, 0,  0, 0,  0,  0, 0, -1, 5, 5, 0);

        // Halt: stop together with a matching read must not count
        cyc("halt_prod",  0, 0, 0,  0, 0, 12,  0, 0, 0, 5, 5, 0);
        cyc("halt_stop",  0, 1, 12, 0, 0, 13,  1, 1, 0, 5, 5, 0);
        cyc("halt_h1",    0, 1, 12, 0, 0,  0,  0, 1, 1, 5, 5, 0);
        cyc("halt_h2",    0, 1, 12, 0, 0,  0,  0, 1, 1, 5, 5, 0);
        cyc("halt_drain", 0, 1, 12, 0, 0,  0,  0, 1, 1, 5, 5, 1);
        cyc("halt_idle",  0, 0, 0,  0, 0,  0,  0, 1, 1, 5, 5, 1);

        // Reset out of halt, then reset during the 2nd stall cycle
        cyc("rst_halt",   1, 0, 0,  0, 0,  0,  0, 0, -1, 5, 5, 0);
        cyc("mr_issue",   0, 0, 0,  0, 0,  5,  0, 0, 0, 0, 0, 0);
        cyc("mr_st1",     0, 1, 5,  0, 0,  0,  0, 1, 0, 0, 0, 0);
        cyc("mr_rst",     1, 1, 5,  0, 0,  0,  0, 0, 0, 1, 1, 0);
        cyc("mr_read",    0, 1, 5,  0, 0,  0,  0, 0, 0, 0, 0, 1);
        cyc("mr_after",   0, 0, 0,  0, 0,  0,  0, 0, 0, 0, 0, 0);

        // Saturation: instruction reads and rewrites r5 forever; every 4th cycle issues
        cyc("sat_rst",    1, 0, 0,  0, 0,  0,  0, 0, -1, -1, -1, 0);
        for (int i = 0; i < 28; i++) begin
            hz = i - (i + 3) / 4;
            cyc("sat_run", 0, 1, 5, 0, 0, 5, 0, ((i % 4) != 0) ? 1 : 0, 0, hz,
                (hz > 15) ? 15 : hz, 0);
        end
        cyc("sat_final",  0, 0, 0,  0, 0,  0,  0, 0, 0, 21, 15, 1);
        cyc("sat_hold",   0, 0, 0,  0, 0,  0,  0, 0, 0, 21, 15, 0);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
